// File: rtl/serial_negate_ctrl_if.sv
// Handshake/data bundle between a parallel producer/consumer and serial_negate_ctrl.
// The overflow signal exists only when NEG_OVERFLOW_EN is defined.
interface serial_negate_ctrl_if #(
    parameter int W = 8
);
    logic         start;
    logic [W-1:0] data_in;
    logic [W-1:0] result;
    logic         busy;
    logic         done;
    logic         ser_bit;
`ifdef NEG_OVERFLOW_EN
    logic         overflow;

    modport master (output start, data_in, input result, busy, done, ser_bit, overflow);
    modport slave  (input start, data_in, output result, busy, done, ser_bit, overflow);
`else
    modport master (output start, data_in, input result, busy, done, ser_bit);
    modport slave  (input start, data_in, output result, busy, done, ser_bit);
`endif
endinterface

// File: rtl/serial_negate_ctrl.sv
// Bit-serial two's-complement negation controller: loads a word, shifts it LSB-first
// through a PASS/INVERT complementer and reassembles the result. Optional: NEG_OVERFLOW_EN.
module serial_negate_ctrl #(
    parameter int W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    serial_negate_ctrl_if.slave    bus
);
    localparam int CW = (W > 2) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state;
    logic          comp_inv;
    logic [CW-1:0] cnt;
    logic [W-1:0]  opnd;
    logic [W-1:0]  result_q;
    logic          busy_q;
    logic          done_q;
    logic          accept;
    logic          ser;
`ifdef NEG_OVERFLOW_EN
    logic          ovf_q;
`endif

    assign accept = bus.start && (state != SHIFT);
    assign ser    = (state == SHIFT) && (opnd[0] ^ comp_inv);

    assign bus.ser_bit = ser;
    assign bus.result  = result_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
`ifdef NEG_OVERFLOW_EN
    assign bus.overflow = ovf_q;
`endif

    // Operand shift register is pure data; it is always reloaded before use.
    always_ff @(posedge clk) begin
        if (accept)
            opnd <= bus.data_in;
        else if (state == SHIFT)
            opnd <= opnd >> 1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            comp_inv <= 1'b0;
            cnt      <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef NEG_OVERFLOW_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state    <= SHIFT;
                        cnt      <= '0;
                        comp_inv <= 1'b0;
                        busy_q   <= 1'b1;
`ifdef NEG_OVERFLOW_EN
                        ovf_q    <= 1'b0;
`endif
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    result_q <= {ser, result_q[W-1:1]};
                    comp_inv <= comp_inv | opnd[0];
                    cnt      <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
`ifdef NEG_OVERFLOW_EN
                        // Only the most-negative word negates to itself: final value is 100..0.
                        ovf_q  <= ser && (result_q[W-1:1] == '0);
`endif
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_negate_ctrl.sv
// Directed self-checking bench for serial_negate_ctrl (W=8).
module tb_serial_negate_ctrl;
    localparam int W = 8;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    serial_negate_ctrl_if #(.W(W)) bus ();

    serial_negate_ctrl #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full operation; optionally pulses start with another word during SHIFT.
    task automatic run_op(input logic [7:0] d, input logic [7:0] exp, input int pulse_at,
                          input logic [7:0] pulse_d);
        bus.start   = 1'b1;
        bus.data_in = d;
        tick();
        bus.start   = 1'b0;
        bus.data_in = 8'h00;
        for (int i = 0; i < W; i++) begin
            check("busy_shift", bus.busy, 1'b1);
            check("done_shift", bus.done, 1'b0);
            check("ser_bit", bus.ser_bit, exp[i]);
            if (i == pulse_at) begin
                bus.start   = 1'b1;
                bus.data_in = pulse_d;
            end else begin
                bus.start   = 1'b0;
            end
            tick();
        end
        bus.start = 1'b0;
        check("done_pulse", bus.done, 1'b1);
        check("busy_done", bus.busy, 1'b0);
        check("result", bus.result, exp);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.data_in = 8'h00;
        tick();
        tick();
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_result", bus.result, 8'h00);
        check("rst_ser", bus.ser_bit, 1'b0);
`ifdef NEG_OVERFLOW_EN
        check("rst_ovf", bus.overflow, 1'b0);
`endif
        reset = 1'b0;
        tick();
        check("idle_busy", bus.busy, 1'b0);

        // 0x05 -> 0xFB, then held in IDLE
        run_op(8'h05, 8'hFB, -1, 8'h00);
        tick();
        check("done_clear", bus.done, 1'b0);
        tick();
        tick();
        check("hold_result", bus.result, 8'hFB);
        check("hold_busy", bus.busy, 1'b0);

        // zero stays zero, ser_bit 0 throughout (checked per bit in run_op)
        run_op(8'h00, 8'h00, -1, 8'h00);
        tick();

        // most-negative value maps to itself
        run_op(8'h80, 8'h80, -1, 8'h00);
`ifdef NEG_OVERFLOW_EN
        check("ovf_set", bus.overflow, 1'b1);
`endif
        tick();

        // start during SHIFT is ignored: 0x01 -> 0xFF, single done pulse
        run_op(8'h01, 8'hFF, 2, 8'h7F);
`ifdef NEG_OVERFLOW_EN
        check("ovf_clr", bus.overflow, 1'b0);
`endif
        for (int i = 0; i < W + 2; i++) begin
            tick();
            check("no_extra_done", bus.done, 1'b0);
            check("no_extra_busy", bus.busy, 1'b0);
        end
        check("hold_ff", bus.result, 8'hFF);

        // start held high: back-to-back 0x10 -> 0xF0, 0x40 -> 0xC0, 9 cycles apart
        bus.start   = 1'b1;
        bus.data_in = 8'h10;
        tick();
        for (int i = 0; i < W; i++) begin
            check("b2b_busy1", bus.busy, 1'b1);
            if (i == W - 1) bus.data_in = 8'h40;
            tick();
        end
        check("b2b_done1", bus.done, 1'b1);
        check("b2b_res1", bus.result, 8'hF0);
        tick();
        for (int i = 0; i < W; i++) begin
            check("b2b_busy2", bus.busy, 1'b1);
            check("b2b_nodone", bus.done, 1'b0);
            if (i == W - 1) bus.start = 1'b0;
            tick();
        end
        check("b2b_done2", bus.done, 1'b1);
        check("b2b_res2", bus.result, 8'hC0);
        tick();
        check("b2b_idle", bus.busy, 1'b0);

        // async reset mid-SHIFT
        bus.start   = 1'b1;
        bus.data_in = 8'h33;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check("pre_rst_busy", bus.busy, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy", bus.busy, 1'b0);
        check("arst_done", bus.done, 1'b0);
        check("arst_result", bus.result, 8'h00);
        check("arst_ser", bus.ser_bit, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_idle", bus.busy, 1'b0);
        run_op(8'h02, 8'hFE, -1, 8'h00);
        tick();
        check("final_done_clear", bus.done, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_negate_ctrl.md
# serial_negate_ctrl

Sequencing controller for the bit-serial two's-complement negator. It accepts a parallel W-bit word on a start strobe and shifts the word LSB-first through an internal two-state complementer. The complementer passes bits up to and including the first 1, then inverts every later bit. The controller reassembles the serial output into a parallel result and signals completion. It sits between a parallel producer/consumer and the serial negation datapath, and owns operand load, bit counting, complementer state reset and the start/busy/done handshake.

## Interface
- W, 8, operand/result width in bits; legal range W ≥ 2
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request strobe; sampled on rising clk edge
- data_in  input  W  operand; captured on the accepted start edge only
- result  output  W  negated operand (−data_in mod 2^W); valid while done=1 and held until the next accepted start
- busy  output  1  high while bits are being shifted
- done  output  1  single-cycle completion pulse
- ser_bit  output  1  current serial output bit of the complementer (debug/observation)
- overflow  output  1  present only with NEG_OVERFLOW_EN; see Configuration

## Operation
- Controller states: IDLE, SHIFT, DONE.
- Complementer state is held internally: PASS (no 1 seen yet) and INVERT (a 1 has been seen).
  - PASS with input bit 0: output 0, stay in PASS.
  - PASS with input bit 1: output 1, go to INVERT.
  - INVERT with input bit b: output ~b, stay in INVERT.
- IDLE: busy=0, done=0. If start=1, then:
  - load the shift register with data_in;
  - clear the bit counter to 0;
  - force the complementer to PASS;
  - go to SHIFT.
- SHIFT: busy=1. Each cycle:
  - present shift-register bit 0 to the complementer;
  - shift the complementer output into result from the MSB end (result shifts right);
  - shift the operand register right;
  - increment the counter.
  - When the counter reaches W−1 on an edge, that edge processes the final bit and moves to DONE.
- DONE: done=1, busy=0, and result holds the final value.
  - Next edge: if start=1, treat exactly as start in IDLE (back-to-back operation); otherwise go to IDLE.
- start is ignored in SHIFT. The operand is not re-captured and the counter is not disturbed.
- result is never modified outside SHIFT. It retains its last value through IDLE.
- ser_bit is the combinational complementer output for the current operand LSB. It is 0 outside SHIFT.
- Arithmetic: the result equals (2^W − data_in) mod 2^W.
  - data_in=0 yields 0; the complementer never leaves PASS.
  - data_in=2^(W−1) yields 2^(W−1).

## Timing
- Reset values: state=IDLE, complementer=PASS, counter=0, result=0, busy=0, done=0, ser_bit=0, overflow=0.
- Reset asserted mid-operation aborts immediately and asynchronously to the reset values. The partial result is discarded. Once reset is deasserted, start must be reasserted.
- Latency, with start accepted on edge k:
  - busy is high in the cycles after edges k … k+W−1 (W cycles);
  - done is high for one cycle after edge k+W;
  - result is valid in that same cycle.
- Throughput: one operation per W+1 cycles when start is held high or re-pulsed in DONE.
- start asserted for several cycles during SHIFT produces no extra operations. Only a start sampled in IDLE or DONE is accepted.

## Configuration
- NEG_OVERFLOW_EN defined:
  - adds the overflow output, high together with done when data_in was 2^(W−1) (most-negative value; its negation is unrepresentable);
  - overflow is registered alongside result and cleared on the next accepted start and on reset.
- NEG_OVERFLOW_EN undefined: no overflow port, no detection logic. All other behaviour is identical.

## Test plan
- W=8, start with data_in=0x05 → busy for 8 cycles, done pulse on cycle 9, result=0xFB; result then holds 0xFB in IDLE.
- data_in=0x00 → result=0x00 and ser_bit=0 throughout SHIFT; with NEG_OVERFLOW_EN, data_in=0x80 → result=0x80, overflow=1 with done, overflow=0 after the next start.
- Start with 0x01, then pulse start with 0x7F at cycle 3 of SHIFT → the second start is ignored; result=0xFF and only one done pulse.
- Hold start=1 continuously with data_in=0x10, then 0x40 → two done pulses 9 cycles apart, results 0xF0 then 0xC0.
- Start with 0x33, assert reset asynchronously mid-SHIFT → busy, done and result drop to 0 immediately; a new start with 0x02 yields 0xFE.
